// File: rtl/logic_sweep_ctrl_pkg.sv
// Shared definitions for the exhaustive gate-network sweep controller.
// Holds the state encoding and the width helpers used by the controller, its timer and its interface.
package logic_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_t;

  localparam int NUM_IN_DEFAULT = 3;
  localparam int SETTLE_DEFAULT = 2;

  function automatic int num_vectors(input int num_in);
    return 1 << num_in;
  endfunction

  // Wide enough to hold every count from 0 up to and including SETTLE_CYCLES.
  function automatic int cnt_width(input int settle_cycles);
    return $clog2(settle_cycles + 1);
  endfunction

endpackage

// File: rtl/logic_sweep_ctrl_if.sv
// Control, observation and gate-network signals of the sweep controller.
// The slave modport is the controller's view; the master modport is the board/test side.
interface logic_sweep_ctrl_if #(
  parameter int NUM_IN = logic_sweep_ctrl_pkg::NUM_IN_DEFAULT
);
  import logic_sweep_ctrl_pkg::*;

  localparam int NV = num_vectors(NUM_IN);

  logic              start;
  logic              abort;
  logic              dut_y;
  logic [NUM_IN-1:0] dut_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [NV-1:0]     captured;
  logic [NV-1:0]     fail_vec;

  modport master (
    output start, abort, dut_y,
    input  dut_in, busy, done, pass, captured, fail_vec
  );

  modport slave (
    input  start, abort, dut_y,
    output dut_in, busy, done, pass, captured, fail_vec
  );

endinterface

// File: rtl/logic_circuit.sv
// 3-input gate network under test; with A set the B terms cover every case, with A clear the C terms do,
// so Y is 1 for all eight input combinations.
module logic_circuit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & ~b) | (~a & c) | (~a & ~c);

endmodule

// File: rtl/logic_sweep_ctrl_timer.sv
// Settle-window counter: counts each enabled cycle and wraps to zero on its own terminal count,
// so the controller sees tc exactly once every SETTLE_CYCLES+1 cycles.
module sweep_settle_timer
  import logic_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = cnt_width(SETTLE_CYCLES);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(SETTLE_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Self-test sequencer: walks every input vector through the gate network, samples Y after a settle
// window and compares the captured truth table against GOLDEN.
module logic_sweep_ctrl
  import logic_sweep_ctrl_pkg::*;
#(
  parameter int                              NUM_IN        = NUM_IN_DEFAULT,
  parameter int                              SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter logic [(1 << NUM_IN)-1:0]        GOLDEN        = {(1 << NUM_IN){1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  logic_sweep_ctrl_if.slave   bus
);

  localparam int NV = num_vectors(NUM_IN);

  sweep_state_t      state, state_next;
  logic [NUM_IN-1:0] idx, idx_next;
  logic [NUM_IN-1:0] dut_in_r, dut_in_next;
  logic [NV-1:0]     captured_r, captured_next;
  logic [NV-1:0]     fail_r, fail_next;
  logic              busy_r, busy_next;
  logic              done_r, done_next;
  logic              pass_r, pass_next;
  logic              tc;

  // The timer only runs in RUN, so every sweep starts with a fresh settle window.
  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != ST_RUN) || bus.abort),
    .enable (state == ST_RUN),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      dut_in_r   <= '0;
      captured_r <= '0;
      fail_r     <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      dut_in_r   <= dut_in_next;
      captured_r <= captured_next;
      fail_r     <= fail_next;
      busy_r     <= busy_next;
      done_r     <= done_next;
      pass_r     <= pass_next;
    end
  end

  // Abort overrides everything but leaves the partial capture visible for debug.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    dut_in_next   = dut_in_r;
    captured_next = captured_r;
    fail_next     = fail_r;
    busy_next     = busy_r;
    done_next     = done_r;
    pass_next     = pass_r;

    if (bus.abort) begin
      state_next  = ST_IDLE;
      idx_next    = '0;
      dut_in_next = '0;
      busy_next   = 1'b0;
      done_next   = 1'b0;
      pass_next   = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_next    = ST_RUN;
            idx_next      = '0;
            dut_in_next   = '0;
            captured_next = '0;
            fail_next     = '0;
            busy_next     = 1'b1;
            done_next     = 1'b0;
            pass_next     = 1'b0;
          end
        end
        ST_RUN: begin
          if (tc) begin
            captured_next[idx] = bus.dut_y;
            fail_next[idx]     = bus.dut_y ^ GOLDEN[idx];
            if (idx == NUM_IN'(NV - 1)) begin
              state_next = ST_DONE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
              pass_next  = ~|fail_next;
            end else begin
              idx_next    = idx + NUM_IN'(1);
              dut_in_next = idx + NUM_IN'(1);
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dut_in   = dut_in_r;
  assign bus.captured = captured_r;
  assign bus.fail_vec = fail_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Directed bench: three controllers (default, mismatching golden, short settle) share start/abort/rst
// and each drives its own copy of the real gate network.
module tb_logic_sweep_ctrl;
  import logic_sweep_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic force_low = 1'b0;
  logic y_a, y_g, y_s;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic_sweep_ctrl_if #(.NUM_IN(3)) bus_a ();
  logic_sweep_ctrl_if #(.NUM_IN(3)) bus_g ();
  logic_sweep_ctrl_if #(.NUM_IN(3)) bus_s ();

  logic_circuit gate_a (.a(bus_a.dut_in[2]), .b(bus_a.dut_in[1]), .c(bus_a.dut_in[0]), .y(y_a));
  logic_circuit gate_g (.a(bus_g.dut_in[2]), .b(bus_g.dut_in[1]), .c(bus_g.dut_in[0]), .y(y_g));
  logic_circuit gate_s (.a(bus_s.dut_in[2]), .b(bus_s.dut_in[1]), .c(bus_s.dut_in[0]), .y(y_s));

  assign bus_a.start = start;
  assign bus_a.abort = abort;
  assign bus_a.dut_y = y_a;
  assign bus_g.start = start;
  assign bus_g.abort = abort;
  assign bus_g.dut_y = y_g;
  assign bus_s.start = start;
  assign bus_s.abort = abort;
  assign bus_s.dut_y = y_s & ~force_low;

  logic_sweep_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus_a));
  logic_sweep_ctrl #(.GOLDEN(8'hFB)) u_dut_g (.clk(clk), .rst(rst), .bus(bus_g));
  logic_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  // Helpers leave the bench 1 time unit after the last rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus_a.busy, bus_a.done, bus_a.pass}); end
    total++; if (bus_a.dut_in !== 3'd0) begin bad++; $display("[TB] FAIL reset_dut_in: got %0d expected 0", bus_a.dut_in); end
    total++; if ({bus_a.captured, bus_a.fail_vec} !== 16'h0000) begin bad++; $display("[TB] FAIL reset_capture: got %h expected 0000", {bus_a.captured, bus_a.fail_vec}); end
    rst = 1'b0;
    step(1);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset: busy got %b expected 0", bus_a.busy); end
  endtask

  task automatic test_full_sweep();
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step(1);
      total++; if (bus_a.dut_in !== 3'(k / 3)) begin bad++; $display("[TB] FAIL sweep_dut_in[%0d]: got %0d expected %0d", k, bus_a.dut_in, k / 3); end
      total++; if ({bus_a.busy, bus_a.done} !== 2'b10) begin bad++; $display("[TB] FAIL sweep_busy_done[%0d]: got %b expected 10", k, {bus_a.busy, bus_a.done}); end
    end
    step(1);
    total++; if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b011) begin bad++; $display("[TB] FAIL sweep_end_flags: got %b expected 011", {bus_a.busy, bus_a.done, bus_a.pass}); end
    total++; if (bus_a.captured !== 8'hFF) begin bad++; $display("[TB] FAIL sweep_captured: got %h expected ff", bus_a.captured); end
    total++; if (bus_a.fail_vec !== 8'h00) begin bad++; $display("[TB] FAIL sweep_fail_vec: got %h expected 00", bus_a.fail_vec); end
    total++; if (bus_a.dut_in !== 3'd7) begin bad++; $display("[TB] FAIL done_dut_in: got %0d expected 7", bus_a.dut_in); end
  endtask

  task automatic test_golden_mismatch();
    pulse_start();
    step(23);
    total++; if (bus_g.done !== 1'b0) begin bad++; $display("[TB] FAIL golden_early_done: got %b expected 0", bus_g.done); end
    step(1);
    total++; if ({bus_g.done, bus_g.pass} !== 2'b10) begin bad++; $display("[TB] FAIL golden_done_pass: got %b expected 10", {bus_g.done, bus_g.pass}); end
    total++; if (bus_g.fail_vec !== 8'h04) begin bad++; $display("[TB] FAIL golden_fail_vec: got %h expected 04", bus_g.fail_vec); end
    total++; if (bus_g.captured !== 8'hFF) begin bad++; $display("[TB] FAIL golden_captured: got %h expected ff", bus_g.captured); end
  endtask

  task automatic test_abort();
    pulse_start();
    step(9);
    total++; if (bus_a.dut_in !== 3'd3) begin bad++; $display("[TB] FAIL abort_pre_idx: got %0d expected 3", bus_a.dut_in); end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    total++; if ({bus_a.busy, bus_a.done, bus_a.pass} !== 3'b000) begin bad++; $display("[TB] FAIL abort_flags: got %b expected 000", {bus_a.busy, bus_a.done, bus_a.pass}); end
    total++; if (bus_a.dut_in !== 3'd0) begin bad++; $display("[TB] FAIL abort_dut_in: got %0d expected 0", bus_a.dut_in); end
    total++; if (bus_a.captured !== 8'h07) begin bad++; $display("[TB] FAIL abort_captured: got %h expected 07", bus_a.captured); end
    step(3);
    total++; if ({bus_a.busy, bus_a.dut_in} !== 4'b0000) begin bad++; $display("[TB] FAIL abort_stays_idle: got %b expected 0000", {bus_a.busy, bus_a.dut_in}); end
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_beats_start: busy got %b expected 0", bus_a.busy); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    total++; if ({bus_a.busy, bus_a.dut_in} !== 4'b1001) begin bad++; $display("[TB] FAIL restart_ignored: got %b expected 1001", {bus_a.busy, bus_a.dut_in}); end
    step(18);
    total++; if ({bus_a.done, bus_a.dut_in} !== 4'b0111) begin bad++; $display("[TB] FAIL restart_cycle23: got %b expected 0111", {bus_a.done, bus_a.dut_in}); end
    step(1);
    total++; if ({bus_a.done, bus_a.captured} !== 9'h1FF) begin bad++; $display("[TB] FAIL restart_cycle24: got %h expected 1ff", {bus_a.done, bus_a.captured}); end
    pulse_start();
    total++; if ({bus_a.busy, bus_a.done} !== 2'b10) begin bad++; $display("[TB] FAIL rerun_flags: got %b expected 10", {bus_a.busy, bus_a.done}); end
    total++; if ({bus_a.captured, bus_a.fail_vec} !== 16'h0000) begin bad++; $display("[TB] FAIL rerun_cleared: got %h expected 0000", {bus_a.captured, bus_a.fail_vec}); end
    step(24);
    total++; if ({bus_a.done, bus_a.pass, bus_a.captured} !== 10'h3FF) begin bad++; $display("[TB] FAIL rerun_result: got %h expected 3ff", {bus_a.done, bus_a.pass, bus_a.captured}); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    step(6);
    total++; if (bus_a.captured !== 8'h03) begin bad++; $display("[TB] FAIL pre_reset_captured: got %h expected 03", bus_a.captured); end
    #3;
    rst = 1'b1;
    #1;
    total++; if ({bus_a.busy, bus_a.done, bus_a.pass, bus_a.dut_in} !== 6'b000000) begin bad++; $display("[TB] FAIL async_reset_flags: got %b expected 000000", {bus_a.busy, bus_a.done, bus_a.pass, bus_a.dut_in}); end
    total++; if ({bus_a.captured, bus_a.fail_vec} !== 16'h0000) begin bad++; $display("[TB] FAIL async_reset_capture: got %h expected 0000", {bus_a.captured, bus_a.fail_vec}); end
    #2;
    rst = 1'b0;
    step(1);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_idle: busy got %b expected 0", bus_a.busy); end
    pulse_start();
    step(24);
    total++; if ({bus_a.done, bus_a.pass, bus_a.captured, bus_a.fail_vec} !== 18'h3FF00) begin bad++; $display("[TB] FAIL post_reset_sweep: got %h expected 3ff00", {bus_a.done, bus_a.pass, bus_a.captured, bus_a.fail_vec}); end
  endtask

  task automatic test_settle_glitch();
    pulse_start();
    step(10);
    total++; if (bus_s.dut_in !== 3'd5) begin bad++; $display("[TB] FAIL short_settle_vec5: got %0d expected 5", bus_s.dut_in); end
    force_low = 1'b1;
    step(1);
    force_low = 1'b0;
    step(4);
    total++; if (bus_s.done !== 1'b0) begin bad++; $display("[TB] FAIL short_settle_early: done got %b expected 0", bus_s.done); end
    step(1);
    total++; if ({bus_s.done, bus_s.pass, bus_s.captured, bus_s.fail_vec} !== 18'h3FF00) begin bad++; $display("[TB] FAIL glitch_ignored: got %h expected 3ff00", {bus_s.done, bus_s.pass, bus_s.captured, bus_s.fail_vec}); end
    pulse_start();
    step(11);
    force_low = 1'b1;
    step(1);
    force_low = 1'b0;
    step(4);
    total++; if (bus_s.fail_vec !== 8'h20) begin bad++; $display("[TB] FAIL sample_fail_vec: got %h expected 20", bus_s.fail_vec); end
    total++; if ({bus_s.done, bus_s.pass, bus_s.captured} !== 10'h2DF) begin bad++; $display("[TB] FAIL sample_result: got %h expected 2df", {bus_s.done, bus_s.pass, bus_s.captured}); end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_golden_mismatch();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_settle_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
